scroll_addr_gen: RTL and testbench

Parametrised frame-buffer address generator for the VGA display path. Sits between the VGA timing controller and the image block RAM. Maps each active screen pixel to a source-image address with integer downscaling, independent horizontal and vertical mirroring, and two-axis wrap-around scrolling at a programmable speed. All mode changes take effect only on frame boundaries, so a frame never tears.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/scroll_addr_gen_if.sv | 34 +++
 rtl/scroll_offset_ctrl.sv | 92 +++++++++
 rtl/scroll_addr_gen.sv | 97 +++++++++
 tb/tb_scroll_addr_gen.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path.
//   - scroll direction encodings (DIR_*)
//   - default screen / image dimensions
//   - mode_t: the per-frame mode word that is shadowed at frame boundaries
//   - wrap_add / wrap_sub: modulo helpers for operands already below the modulus
package vga_pkg;

    localparam logic [1:0] DIR_YINC = 2'b00;
    localparam logic [1:0] DIR_YDEC = 2'b01;
    localparam logic [1:0] DIR_XINC = 2'b10;
    localparam logic [1:0] DIR_XDEC = 2'b11;

    localparam int unsigned DEF_H_ACT = 640;
    localparam int unsigned DEF_V_ACT = 480;
    localparam int unsigned DEF_IMG_W = 320;
    localparam int unsigned DEF_IMG_H = 240;

    typedef struct packed {
        logic       en;
        logic [1:0] dir;
        logic [3:0] step;
        logic       hmir;
        logic       vmir;
    } mode_t;

    // (a + b) mod dim, valid when a < dim and b < dim.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned dim);
        int unsigned s;
        s = a + b;
        return (s >= dim) ? s - dim : s;
    endfunction

    // (a - b) mod dim, valid when a < dim and b < dim.
    function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                             input int unsigned dim);
        return (b > a) ? a + dim - b : a - b;
    endfunction

endpackage

// File: rtl/scroll_addr_gen_if.sv
// Bus between the VGA timing/control side (master) and scroll_addr_gen (slave).
//   master -> slave : h_cnt, v_cnt, valid, en, dir, step, hmir, vmir
//   slave -> master : pixel_addr, addr_valid, frame_tick, x_off, y_off,
//                     mode (shadow mode word in force for the current frame)
interface scroll_addr_gen_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8
);
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic              valid;
    logic              en;
    logic [1:0]        dir;
    logic [3:0]        step;
    logic              hmir;
    logic              vmir;
    logic [ADDR_W-1:0] pixel_addr;
    logic              addr_valid;
    logic              frame_tick;
    logic [XW-1:0]     x_off;
    logic [YW-1:0]     y_off;
    vga_pkg::mode_t    mode;

    modport master (
        output h_cnt, v_cnt, valid, en, dir, step, hmir, vmir,
        input  pixel_addr, addr_valid, frame_tick, x_off, y_off, mode
    );

    modport slave (
        input  h_cnt, v_cnt, valid, en, dir, step, hmir, vmir,
        output pixel_addr, addr_valid, frame_tick, x_off, y_off, mode
    );
endinterface

// File: rtl/scroll_offset_ctrl.sv
// Frame-rate scroll controller.
// Detects the frame boundary (last active pixel), shadows the mode word there,
// counts frames 0..STEP_DIV-1 and moves the selected offset by `step` with
// wrap-around when the counter completes and the freshly latched enable is set.
//   clk, rst          : pixel clock, async active-low reset
//   h_cnt_i/v_cnt_i   : screen position, valid_i marks active area
//   mode_i            : live mode inputs; mode_o : shadowed mode for this frame
//   x_off_o/y_off_o   : scroll offsets; frame_tick_o : pulse after the boundary
module scroll_offset_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned H_ACT    = DEF_H_ACT,
    parameter int unsigned V_ACT    = DEF_V_ACT,
    parameter int unsigned STEP_DIV = 1,
    parameter int unsigned XW       = $clog2(IMG_W),
    parameter int unsigned YW       = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    h_cnt_i,
    input  logic [9:0]    v_cnt_i,
    input  logic          valid_i,
    input  mode_t         mode_i,
    output mode_t         mode_o,
    output logic [XW-1:0] x_off_o,
    output logic [YW-1:0] y_off_o,
    output logic          frame_tick_o
);

    localparam int unsigned FW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [FW-1:0] FLast = FW'(STEP_DIV - 1);

    logic          boundary;
    logic [FW-1:0] fcnt_q, fcnt_d;
    mode_t         mode_q, mode_d;
    logic [XW-1:0] x_off_q, x_off_d;
    logic [YW-1:0] y_off_q, y_off_d;
    logic          tick_q, tick_d;

    assign boundary = valid_i && (h_cnt_i == 10'(H_ACT - 1)) && (v_cnt_i == 10'(V_ACT - 1));

    always_comb begin
        fcnt_d  = fcnt_q;
        mode_d  = mode_q;
        x_off_d = x_off_q;
        y_off_d = y_off_q;
        tick_d  = 1'b0;
        if (boundary) begin
            mode_d = mode_i;
            tick_d = 1'b1;
            if (fcnt_q == FLast) begin
                fcnt_d = '0;
                // The move uses the mode being latched now, not the old shadow.
                if (mode_i.en) begin
                    unique case (mode_i.dir)
                        DIR_YINC: y_off_d = YW'(wrap_add(32'(y_off_q), 32'(mode_i.step), IMG_H));
                        DIR_YDEC: y_off_d = YW'(wrap_sub(32'(y_off_q), 32'(mode_i.step), IMG_H));
                        DIR_XINC: x_off_d = XW'(wrap_add(32'(x_off_q), 32'(mode_i.step), IMG_W));
                        DIR_XDEC: x_off_d = XW'(wrap_sub(32'(x_off_q), 32'(mode_i.step), IMG_W));
                        default: ;
                    endcase
                end
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q  <= '0;
            mode_q  <= '0;
            x_off_q <= '0;
            y_off_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            mode_q  <= mode_d;
            x_off_q <= x_off_d;
            y_off_q <= y_off_d;
            tick_q  <= tick_d;
        end
    end

    assign mode_o       = mode_q;
    assign x_off_o      = x_off_q;
    assign y_off_o      = y_off_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/scroll_addr_gen.sv
// Frame-buffer address generator: screen pixel -> source image address with
// integer downscale, per-frame mirroring and wrap-around scrolling.
// Two-stage pipeline: stage 1 registers (col, row), stage 2 registers
// pixel_addr = row*IMG_W + col together with addr_valid.
//   clk, rst : pixel clock, async active-low reset
//   bus      : slave side of scroll_addr_gen_if (see interface header)
module scroll_addr_gen
    import vga_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned SCALE_SH = 1,
    parameter int unsigned H_ACT    = DEF_H_ACT,
    parameter int unsigned V_ACT    = DEF_V_ACT,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    scroll_addr_gen_if.slave  bus
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    mode_t             mode_in;
    mode_t             mode_act;
    logic [XW-1:0]     x_off;
    logic [YW-1:0]     y_off;
    logic              frame_tick;

    logic [XW-1:0]     sx, sx_m, col_d, col_q;
    logic [YW-1:0]     sy, sy_m, row_d, row_q;
    logic              vld_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              addr_valid_q;

    assign mode_in = {bus.en, bus.dir, bus.step, bus.hmir, bus.vmir};

    scroll_offset_ctrl #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .H_ACT    (H_ACT),
        .V_ACT    (V_ACT),
        .STEP_DIV (STEP_DIV),
        .XW       (XW),
        .YW       (YW)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .h_cnt_i      (bus.h_cnt),
        .v_cnt_i      (bus.v_cnt),
        .valid_i      (bus.valid),
        .mode_i       (mode_in),
        .mode_o       (mode_act),
        .x_off_o      (x_off),
        .y_off_o      (y_off),
        .frame_tick_o (frame_tick)
    );

    // Mirroring uses the shadowed mode so a frame never changes mid-way;
    // it is applied before the scroll offset.
    always_comb begin
        sx    = XW'(bus.h_cnt >> SCALE_SH);
        sy    = YW'(bus.v_cnt >> SCALE_SH);
        sx_m  = mode_act.hmir ? XW'(IMG_W - 1) - sx : sx;
        sy_m  = mode_act.vmir ? YW'(IMG_H - 1) - sy : sy;
        col_d = XW'(wrap_add(32'(sx_m), 32'(x_off), IMG_W));
        row_d = YW'(wrap_add(32'(sy_m), 32'(y_off), IMG_H));
    end

    assign addr_d = ADDR_W'(32'(row_q) * IMG_W + 32'(col_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            vld_q        <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            vld_q        <= bus.valid;
            addr_q       <= addr_d;
            addr_valid_q <= vld_q;
        end
    end

    assign bus.pixel_addr = addr_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.frame_tick = frame_tick;
    assign bus.x_off      = x_off;
    assign bus.y_off      = y_off;
    assign bus.mode       = mode_act;

endmodule

// File: tb/tb_scroll_addr_gen.sv
module tb_scroll_addr_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    scroll_addr_gen_if #(.ADDR_W(17), .XW(9), .YW(8)) bus0 ();
    scroll_addr_gen_if #(.ADDR_W(17), .XW(9), .YW(8)) bus1 ();

    scroll_addr_gen #(
        .IMG_W(320), .IMG_H(240), .SCALE_SH(1), .H_ACT(640), .V_ACT(480),
        .ADDR_W(17), .STEP_DIV(1)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    scroll_addr_gen #(
        .IMG_W(320), .IMG_H(240), .SCALE_SH(1), .H_ACT(640), .V_ACT(480),
        .ADDR_W(17), .STEP_DIV(3)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    task automatic set_pix(input int h, input int v, input logic val);
        @(negedge clk);
        bus0.h_cnt = 10'(h);
        bus0.v_cnt = 10'(v);
        bus0.valid = val;
    endtask

    task automatic set_mode(input logic en, input logic [1:0] dir, input logic [3:0] step,
                            input logic hmir, input logic vmir);
        bus0.en   = en;
        bus0.dir  = dir;
        bus0.step = step;
        bus0.hmir = hmir;
        bus0.vmir = vmir;
    endtask

    // Present one pixel and sample the address after the 2-cycle latency.
    task automatic pix_addr(input int h, input int v, input logic val,
                            output logic [16:0] a, output logic av);
        set_pix(h, v, val);
        @(posedge clk);
        @(posedge clk);
        #1;
        a  = bus0.pixel_addr;
        av = bus0.addr_valid;
    endtask

    // Drive one frame-boundary pixel and sample frame_tick in the next cycle.
    task automatic boundary0(output logic tick);
        set_pix(639, 479, 1'b1);
        @(posedge clk);
        #1;
        tick = bus0.frame_tick;
        set_pix(0, 0, 1'b0);
    endtask

    task automatic test_reset;
        logic [16:0] a;
        rst = 1'b0;
        #5;
        checks++;
        if (bus0.pixel_addr !== 17'd0) begin errors++; $display("FAIL por_addr got %0d want 0", bus0.pixel_addr); end
        checks++;
        if (bus0.addr_valid !== 1'b0 || bus0.frame_tick !== 1'b0) begin
            errors++; $display("FAIL por_flags got av=%b ft=%b want 0 0", bus0.addr_valid, bus0.frame_tick);
        end
        checks++;
        if (bus0.x_off !== 9'd0 || bus0.y_off !== 8'd0) begin
            errors++; $display("FAIL por_off got x=%0d y=%0d want 0 0", bus0.x_off, bus0.y_off);
        end
        set_pix(3, 2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        a = bus0.pixel_addr;
        checks++;
        if (a !== 17'd0) begin errors++; $display("FAIL held_reset_addr got %0d want 0", a); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_static;
        logic [16:0] a;
        logic av;
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b0, 1'b0);
        pix_addr(0, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd0 || av !== 1'b1) begin errors++; $display("FAIL static_0_0 got %0d/%b want 0/1", a, av); end
        pix_addr(639, 479, 1'b1, a, av);
        checks++;
        if (a !== 17'd76799) begin errors++; $display("FAIL static_639_479 got %0d want 76799", a); end
        pix_addr(3, 2, 1'b1, a, av);
        checks++;
        if (a !== 17'd321) begin errors++; $display("FAIL static_3_2 got %0d want 321", a); end
        pix_addr(3, 2, 1'b0, a, av);
        checks++;
        if (a !== 17'd321 || av !== 1'b0) begin errors++; $display("FAIL static_invalid got %0d/%b want 321/0", a, av); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            set_pix(2 * i, 0, 1'b1);
            @(posedge clk);
            #1;
            if (i >= 1) begin
                checks++;
                if (bus0.pixel_addr !== 17'(i - 1)) begin
                    errors++; $display("FAIL stream_%0d got %0d want %0d", i, bus0.pixel_addr, i - 1);
                end
            end
        end
        set_pix(0, 0, 1'b0);
    endtask

    task automatic test_mirror;
        logic [16:0] a;
        logic av, t;
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b1, 1'b0);
        boundary0(t);
        checks++;
        if (t !== 1'b1 || bus0.mode.hmir !== 1'b1) begin
            errors++; $display("FAIL mir_h_tick got ft=%b hmir=%b want 1 1", t, bus0.mode.hmir);
        end
        pix_addr(0, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd319) begin errors++; $display("FAIL mir_h got %0d want 319", a); end
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b0, 1'b1);
        boundary0(t);
        pix_addr(0, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd76480) begin errors++; $display("FAIL mir_v got %0d want 76480", a); end
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b1, 1'b1);
        boundary0(t);
        pix_addr(0, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd76799) begin errors++; $display("FAIL mir_hv got %0d want 76799", a); end
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b0, 1'b0);
        boundary0(t);
    endtask

    task automatic test_wrap;
        logic [16:0] a;
        logic av, t;
        set_mode(1'b1, DIR_YDEC, 4'd1, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (t !== 1'b1 || bus0.y_off !== 8'd239) begin
            errors++; $display("FAIL ydec_wrap got ft=%b y=%0d want 1 239", t, bus0.y_off);
        end
        pix_addr(0, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd76480) begin errors++; $display("FAIL yoff_addr got %0d want 76480", a); end
        pix_addr(0, 2, 1'b1, a, av);
        checks++;
        if (a !== 17'd0) begin errors++; $display("FAIL row_wrap_addr got %0d want 0", a); end
        set_mode(1'b1, DIR_YINC, 4'd1, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (bus0.y_off !== 8'd0) begin errors++; $display("FAIL yinc_wrap got %0d want 0", bus0.y_off); end
        set_mode(1'b1, DIR_XINC, 4'd2, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (bus0.x_off !== 9'd2) begin errors++; $display("FAIL xinc got %0d want 2", bus0.x_off); end
        set_mode(1'b1, DIR_XDEC, 4'd4, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (bus0.x_off !== 9'd318) begin errors++; $display("FAIL xdec_wrap got %0d want 318", bus0.x_off); end
        pix_addr(0, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd318) begin errors++; $display("FAIL xoff_addr got %0d want 318", a); end
        pix_addr(4, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd0) begin errors++; $display("FAIL col_wrap_addr got %0d want 0", a); end
        set_mode(1'b1, DIR_XINC, 4'd2, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (bus0.x_off !== 9'd0) begin errors++; $display("FAIL xinc_wrap got %0d want 0", bus0.x_off); end
        set_mode(1'b1, DIR_XINC, 4'd0, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (bus0.x_off !== 9'd0) begin errors++; $display("FAIL step_zero got %0d want 0", bus0.x_off); end
        set_mode(1'b0, DIR_XINC, 4'd5, 1'b0, 1'b0);
        boundary0(t);
        checks++;
        if (bus0.x_off !== 9'd0 || t !== 1'b1) begin
            errors++; $display("FAIL en_off got x=%0d ft=%b want 0 1", bus0.x_off, t);
        end
    endtask

    task automatic test_tear;
        logic [16:0] a;
        logic av, t;
        pix_addr(0, 100, 1'b1, a, av);
        checks++;
        if (a !== 17'd16000) begin errors++; $display("FAIL tear_before got %0d want 16000", a); end
        set_mode(1'b0, DIR_XINC, 4'd5, 1'b1, 1'b0);
        pix_addr(0, 100, 1'b1, a, av);
        checks++;
        if (a !== 17'd16000) begin errors++; $display("FAIL tear_same_frame got %0d want 16000", a); end
        pix_addr(10, 200, 1'b1, a, av);
        checks++;
        if (a !== 17'd32005) begin errors++; $display("FAIL tear_rest_frame got %0d want 32005", a); end
        checks++;
        if (bus0.mode.hmir !== 1'b0) begin errors++; $display("FAIL tear_shadow got %b want 0", bus0.mode.hmir); end
        boundary0(t);
        pix_addr(0, 100, 1'b1, a, av);
        checks++;
        if (a !== 17'd16319) begin errors++; $display("FAIL tear_next_frame got %0d want 16319", a); end
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b0, 1'b0);
        boundary0(t);
    endtask

    task automatic test_reset_mid;
        logic [16:0] a;
        logic av, t;
        set_mode(1'b1, DIR_XINC, 4'd3, 1'b0, 1'b0);
        boundary0(t);
        pix_addr(4, 0, 1'b1, a, av);
        checks++;
        if (a !== 17'd5 || av !== 1'b1) begin errors++; $display("FAIL pre_rst_addr got %0d/%b want 5/1", a, av); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus0.pixel_addr !== 17'd0 || bus0.addr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_addr got %0d/%b want 0/0", bus0.pixel_addr, bus0.addr_valid);
        end
        checks++;
        if (bus0.x_off !== 9'd0 || bus0.y_off !== 8'd0 || bus0.mode !== 9'd0) begin
            errors++; $display("FAIL mid_rst_state got x=%0d y=%0d mode=%0d want 0 0 0",
                               bus0.x_off, bus0.y_off, bus0.mode);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_pix(2 * i, 10, 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (bus0.frame_tick !== 1'b0) begin errors++; $display("FAIL early_tick_%0d got 1 want 0", i); end
        end
        boundary0(t);
        checks++;
        if (t !== 1'b1 || bus0.x_off !== 9'd3) begin
            errors++; $display("FAIL first_tick got ft=%b x=%0d want 1 3", t, bus0.x_off);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got 1 want 0"); end
        set_mode(1'b0, DIR_YINC, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_rate;
        int exp_x [6] = '{0, 0, 2, 2, 2, 4};
        bus1.en   = 1'b1;
        bus1.dir  = DIR_XINC;
        bus1.step = 4'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus1.h_cnt = 10'd639;
            bus1.v_cnt = 10'd479;
            bus1.valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus1.frame_tick !== 1'b1 || bus1.x_off !== 9'(exp_x[i])) begin
                errors++; $display("FAIL rate_%0d got ft=%b x=%0d want 1 %0d", i, bus1.frame_tick,
                                   bus1.x_off, exp_x[i]);
            end
            @(negedge clk);
            bus1.valid = 1'b0;
            bus1.h_cnt = 10'd0;
            bus1.v_cnt = 10'd0;
            @(posedge clk);
        end
    endtask

    initial begin
        bus0.h_cnt = '0; bus0.v_cnt = '0; bus0.valid = 1'b0;
        bus0.en = 1'b0; bus0.dir = '0; bus0.step = '0; bus0.hmir = 1'b0; bus0.vmir = 1'b0;
        bus1.h_cnt = '0; bus1.v_cnt = '0; bus1.valid = 1'b0;
        bus1.en = 1'b0; bus1.dir = '0; bus1.step = '0; bus1.hmir = 1'b0; bus1.vmir = 1'b0;
        test_reset();
        test_static();
        test_back_to_back();
        test_mirror();
        test_wrap();
        test_tear();
        test_reset_mid();
        test_rate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
